// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains bytes from a FIFO read port into a valid/ready byte stream (optional FIFO_DRAIN_PARITY_EN adds m_parity)
module fifo_drain #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             empty,
  input  logic [7:0]       data_out,
  output logic             rd_cs,
  output logic             rd_en,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] byte_cnt
`ifdef FIFO_DRAIN_PARITY_EN
  ,
  output logic             m_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   armed_q;
  logic   load;
  logic   accept;

  // Holds off the first read decision by one edge after reset release so the
  // FIFO sees rd_en no earlier than the second rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; read strobes only in READ, valid only in HOLD.
  always_comb begin
    state_d = state_q;
    rd_cs   = 1'b0;
    rd_en   = 1'b0;
    m_valid = 1'b0;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && enable && !empty) begin
          state_d = READ;
        end
      end
      READ: begin
        rd_cs   = 1'b1;
        rd_en   = 1'b1;
        state_d = CAPT;
      end
      CAPT: begin
        load    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          accept  = 1'b1;
          state_d = (enable && !empty) ? READ : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Captures the FIFO read data one cycle after rd_en; held through HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= 8'h00;
    end else if (load) begin
      m_data <= data_out;
    end
  end

`ifdef FIFO_DRAIN_PARITY_EN
  // Odd parity registered alongside the captured byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_parity <= 1'b0;
    end else if (load) begin
      m_parity <= ~^data_out;
    end
  end
`endif

  // Counts accepted bytes; wraps silently at the counter width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of the delivered-byte counter.
REQ-002 SHALL provide port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port enable  input  1  permits new FIFO reads when 1.
REQ-005 SHALL provide port empty  input  1  FIFO empty flag.
REQ-006 SHALL provide port data_out  input  8  FIFO read data, valid the cycle after rd_en.
REQ-007 SHALL provide port rd_cs  output  1  FIFO read chip-select.
REQ-008 SHALL provide port rd_en  output  1  FIFO read enable.
REQ-009 SHALL provide port m_data  output  8  byte presented downstream.
REQ-010 SHALL provide port m_valid  output  1  m_data valid.
REQ-011 SHALL provide port m_ready  input  1  downstream accepts m_data.
REQ-012 SHALL provide port byte_cnt  output  CNT_W  count of accepted bytes.
REQ-013 SHALL provide port m_parity  output  1  odd parity of m_data, present only with FIFO_DRAIN_PARITY_EN.

Function
REQ-014 SHALL implement a 4-state FSM: IDLE, READ, CAPT, HOLD.
REQ-015 IDLE: SHALL go to READ when enable=1 and empty=0, else stay IDLE.
REQ-016 READ: SHALL drive rd_cs=1 and rd_en=1 for exactly this one cycle, then go to CAPT unconditionally.
REQ-017 rd_cs and rd_en SHALL be 0 in every state other than READ.
REQ-018 CAPT: SHALL load m_data from data_out at the end of this cycle, then go to HOLD.
REQ-019 HOLD: SHALL drive m_valid=1 and hold m_data stable until m_ready=1 is sampled.
REQ-020 HOLD with m_ready=1: SHALL increment byte_cnt by 1 and go to READ if enable=1 and empty=0, else IDLE.
REQ-021 m_valid SHALL be 1 only in HOLD; it SHALL be 0 the cycle after acceptance.
REQ-022 Maximum throughput SHALL be one byte per 3 cycles (READ, CAPT, HOLD with m_ready=1).
REQ-023 enable=0 during READ, CAPT or HOLD SHALL NOT abort the transaction; it only blocks the next read.
REQ-024 m_ready=1 outside HOLD SHALL be ignored.
REQ-025 rd_en SHALL never be asserted unless empty=0 was sampled at the IDLE/HOLD exit decision.
REQ-026 byte_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE and rd_cs, rd_en, m_valid, m_data, byte_cnt (and m_parity) to 0.
REQ-028 Reset mid-transaction SHALL discard the in-flight byte; no retry on release.
REQ-029 After rst returns to 1, the first rd_en SHALL occur no earlier than the second rising edge.

Configuration
REQ-030 With FIFO_DRAIN_PARITY_EN defined, m_parity SHALL be registered with m_data in CAPT and equal the XNOR-reduction of the captured byte (odd parity).
REQ-031 Without FIFO_DRAIN_PARITY_EN, the m_parity port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 FIFO holds 0xA5, enable=1, m_ready=1 -> rd_en one cycle, m_data=0xA5 with m_valid after 2 cycles, byte_cnt=1, FSM back in IDLE.
REQ-033 FIFO holds 0x01,0x02,0x03, m_ready=1 -> bytes delivered in order, rd_en pulses spaced 3 cycles, byte_cnt=3.
REQ-034 m_data=0x3C in HOLD, m_ready=0 for 10 cycles -> m_valid and m_data stable, no rd_en, byte_cnt unchanged.
REQ-035 rst=0 asserted in CAPT -> all outputs 0 that cycle, byte not delivered, byte_cnt=0.
REQ-036 CNT_W=4, 17 bytes accepted -> byte_cnt=1 after wrap.
REQ-037 FIFO_DRAIN_PARITY_EN defined, bytes 0x00 and 0x07 -> m_parity=1 then 0.
